// File: rtl/hex_scroll_monitor.sv
// Scoreboard for the eight-digit scrolling HELLO display: decodes the glyphs and checks frame-to-frame rotation.
// Optional build macro SCROLL_CONTENT_CHECK_EN: also require the content to be a rotation of "HELLO___".
module hex_scroll_monitor #(
  parameter int FCW = 16,
  parameter int DIR = 0
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           frame_stb,
  input  logic [6:0]     seg0,
  input  logic [6:0]     seg1,
  input  logic [6:0]     seg2,
  input  logic [6:0]     seg3,
  input  logic [6:0]     seg4,
  input  logic [6:0]     seg5,
  input  logic [6:0]     seg6,
  input  logic [6:0]     seg7,
  output logic [23:0]    chars,
  output logic           locked,
  output logic           err,
  output logic [7:0]     err_cnt,
  output logic [FCW-1:0] frame_cnt,
  output logic [2:0]     h_pos
);

  localparam logic [2:0]  CODE_H       = 3'd0;
  localparam logic [2:0]  CODE_INVALID = 3'd7;
  localparam logic [23:0] ALL_BLANK    = 24'h924924;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [23:0]    chars_q, chars_d;
  logic           locked_q, locked_d;
  logic           err_q, err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]     h_pos_q, h_pos_d;

  logic [6:0]  seg_arr [8];
  logic [23:0] new_frame;
  logic [23:0] rot_frame;
  logic [7:0]  invalid_vec;
  logic [2:0]  h_pos_new;
  logic        content_ok;
  logic        match;

  function automatic logic [2:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'b0001001: return 3'd0;
      7'b0000110: return 3'd1;
      7'b1000111: return 3'd2;
      7'b1000000: return 3'd3;
      7'b1111111: return 3'd4;
      default:    return CODE_INVALID;
    endcase
  endfunction

  assign seg_arr[0] = seg0;
  assign seg_arr[1] = seg1;
  assign seg_arr[2] = seg2;
  assign seg_arr[3] = seg3;
  assign seg_arr[4] = seg4;
  assign seg_arr[5] = seg5;
  assign seg_arr[6] = seg6;
  assign seg_arr[7] = seg7;

  // rot_frame is what the stored frame should look like after one scroll step
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      localparam int SRC = (DIR == 0) ? ((gi + 7) % 8) : ((gi + 1) % 8);
      assign new_frame[3*gi +: 3] = decode_glyph(seg_arr[gi]);
      assign invalid_vec[gi]      = (new_frame[3*gi +: 3] == CODE_INVALID);
      assign rot_frame[3*gi +: 3] = chars_q[3*SRC +: 3];
    end
  endgenerate

`ifdef SCROLL_CONTENT_CHECK_EN
  // HEX7..HEX0 = H,E,L,L,O,_,_,_ ; doubling the word lets every rotation be a plain slice
  localparam logic [23:0] HELLO_BASE = 24'h052724;
  localparam logic [47:0] HELLO_DBL  = {HELLO_BASE, HELLO_BASE};
  logic [7:0] content_hit;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_content
      assign content_hit[gi] = (new_frame == HELLO_DBL[3*gi +: 24]);
    end
  endgenerate
  assign content_ok = |content_hit;
`else
  assign content_ok = 1'b1;
`endif

  assign match = ~|invalid_vec && (new_frame == rot_frame) && content_ok;

  always_comb begin
    h_pos_new = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (new_frame[3*i +: 3] == CODE_H) h_pos_new = i[2:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    chars_d     = chars_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    h_pos_d     = h_pos_q;
    if (frame_stb) begin
      chars_d = new_frame;
      h_pos_d = h_pos_new;
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (match) state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (match) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      chars_q     <= ALL_BLANK;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      frame_cnt_q <= '0;
      h_pos_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      chars_q     <= chars_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      h_pos_q     <= h_pos_d;
    end
  end

  assign chars     = chars_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign h_pos     = h_pos_q;

endmodule
